// File: rtl/fft_frame_sched.sv
// Double-buffered frame scheduler: packs SPI bytes into two sample-RAM banks
// and hands each completed bank to the FFT core, with overrun drop and watchdog abort.
module fft_frame_sched #(
  parameter int N        = 9,
  parameter int FFT_SIZE = 512,
  parameter int TIMEOUT  = 65535
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         spi_tran_done,
  input  logic [7:0]   din_spi,
  output logic         wr_en,
  output logic [N:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic         fft_start,
  output logic         fft_bank,
  input  logic         fft_done,
  output logic         frame_drop,
  output logic         fft_timeout,
  output logic [7:0]   frame_cnt
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [2:0]     sync;
  logic           byte_stb;
  logic [7:0]     data_r;
  logic [N-1:0]   idx;
  logic           fill_bank, drop_r, end_pend;
  logic [1:0]     ready, set_mask, clr_mask;
  logic           dropping, rel;
  state_t         state;
  logic           rd_bank;
  logic [WDW-1:0] wd;

  // sync[1:0] is the 2-FF synchronizer, sync[2] the edge register.
  // din_spi is captured one edge after the level is first seen, while it is known stable.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync     <= '0;
      byte_stb <= 1'b0;
      data_r   <= '0;
    end else begin
      sync     <= {sync[1:0], spi_tran_done};
      byte_stb <= sync[1] & ~sync[2];
      if (sync[0] & ~sync[1]) data_r <= din_spi;
    end
  end

  // Drop decision is taken once at index 0 and held for the whole frame.
  assign dropping = (idx == '0) ? ready[fill_bank] : drop_r;
  assign rel      = (state == S_WAIT) && (fft_done || wd == WDW'(TIMEOUT - 1));
  assign set_mask = {end_pend & ~drop_r & fill_bank, end_pend & ~drop_r & ~fill_bank};
  assign clr_mask = {rel & rd_bank, rel & ~rd_bank};

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      fill_bank  <= 1'b0;
      drop_r     <= 1'b0;
      end_pend   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= end_pend & drop_r;
      if (end_pend && !drop_r) fill_bank <= ~fill_bank;
      if (byte_stb) begin
        wr_en    <= ~dropping;
        wr_addr  <= {fill_bank, idx};
        wr_data  <= data_r;
        idx      <= idx + 1'b1;
        drop_r   <= dropping;
        end_pend <= (idx == N'(FFT_SIZE - 1));
      end else begin
        wr_en    <= 1'b0;
        end_pend <= 1'b0;
      end
    end
  end

  // Set (frame end) and clear (done/abort) always target different banks.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) ready <= '0;
    else        ready <= (ready & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rd_bank     <= 1'b0;
      wd          <= '0;
      fft_start   <= 1'b0;
      fft_bank    <= 1'b0;
      fft_timeout <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      fft_start   <= 1'b0;
      fft_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ready[rd_bank]) begin
            fft_start <= 1'b1;
            fft_bank  <= rd_bank;
            frame_cnt <= frame_cnt + 8'd1;
            wd        <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rel) begin
            fft_timeout <= ~fft_done;
            rd_bank     <= ~rd_bank;
            state       <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
